// File: rtl/version_store.sv
// rtl/version_store.sv - versioned slot store: tagged writes with oldest-tag eviction,
// reads return the newest slot whose tag does not exceed the requested version.
module version_store #(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4,
  parameter int VERSION_NUM   = 4
) (
  input  logic                               clk,
  input  logic                               rstN,
  input  logic                               wrValid,
  output logic                               wrReady,
  input  logic [VERSION_WIDTH-1:0]           wrVersion,
  input  logic [DATA_WIDTH-1:0]              wrData,
  input  logic                               rdValid,
  output logic                               rdReady,
  input  logic [VERSION_WIDTH-1:0]           readVersion,
  output logic                               respValid,
  input  logic                               respReady,
  output logic [DATA_WIDTH-1:0]              dataOut,
  output logic                               hit,
  output logic [$clog2(VERSION_NUM+1)-1:0]   count,
  output logic                               drop
);

  localparam int IDX_W = $clog2(VERSION_NUM);
  localparam int CNT_W = $clog2(VERSION_NUM + 1);

  logic [VERSION_NUM-1:0]   r_valid;
  logic [VERSION_WIDTH-1:0] r_tag  [VERSION_NUM];
  logic [DATA_WIDTH-1:0]    r_data [VERSION_NUM];
  logic [CNT_W-1:0]         r_count;
  logic                     r_resp_valid;
  logic                     r_hit;
  logic [DATA_WIDTH-1:0]    r_data_out;
  logic                     r_drop;

  logic                     w_wr_fire;
  logic                     w_rd_fire;
  logic                     w_match;
  logic [IDX_W-1:0]         w_match_idx;
  logic                     w_free;
  logic [IDX_W-1:0]         w_free_idx;
  logic                     w_min_found;
  logic [VERSION_WIDTH-1:0] w_min_tag;
  logic [IDX_W-1:0]         w_min_idx;
  logic                     w_wr_en;
  logic [IDX_W-1:0]         w_wr_idx;
  logic                     w_count_inc;
  logic                     w_discard;
  logic                     w_rd_hit;
  logic [VERSION_WIDTH-1:0] w_rd_tag;
  logic [DATA_WIDTH-1:0]    w_rd_data;

  // Write side is always ready outside reset, so it follows rstN directly.
  assign wrReady   = rstN;
  assign rdReady   = !r_resp_valid || respReady;
  assign w_wr_fire = wrValid && wrReady;
  assign w_rd_fire = rdValid && rdReady;

  assign respValid = r_resp_valid;
  assign hit       = r_hit;
  assign dataOut   = r_data_out;
  assign count     = r_count;
  assign drop      = r_drop;

  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    w_free      = 1'b0;
    w_free_idx  = '0;
    w_min_found = 1'b0;
    w_min_tag   = '0;
    w_min_idx   = '0;
    for (int i = 0; i < VERSION_NUM; i++) begin
      if (r_valid[i] && (r_tag[i] == wrVersion) && !w_match) begin
        w_match     = 1'b1;
        w_match_idx = IDX_W'(i);
      end
      if (!r_valid[i] && !w_free) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_valid[i] && (!w_min_found || (r_tag[i] < w_min_tag))) begin
        w_min_found = 1'b1;
        w_min_tag   = r_tag[i];
        w_min_idx   = IDX_W'(i);
      end
    end
  end

  // Priority: overwrite same tag, then fill a free slot, then evict the oldest tag.
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = '0;
    w_count_inc = 1'b0;
    w_discard   = 1'b0;
    if (w_wr_fire) begin
      if (w_match) begin
        w_wr_en  = 1'b1;
        w_wr_idx = w_match_idx;
      end else if (w_free) begin
        w_wr_en     = 1'b1;
        w_wr_idx    = w_free_idx;
        w_count_inc = 1'b1;
      end else if (wrVersion > w_min_tag) begin
        w_wr_en  = 1'b1;
        w_wr_idx = w_min_idx;
      end else begin
        w_discard = 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_hit  = 1'b0;
    w_rd_tag  = '0;
    w_rd_data = '0;
    for (int i = 0; i < VERSION_NUM; i++) begin
      if (r_valid[i] && (r_tag[i] <= readVersion) && (!w_rd_hit || (r_tag[i] > w_rd_tag))) begin
        w_rd_hit  = 1'b1;
        w_rd_tag  = r_tag[i];
        w_rd_data = r_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_valid      <= '0;
      r_count      <= '0;
      r_drop       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_hit        <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_drop <= w_discard;
      if (w_wr_en) begin
        r_valid[w_wr_idx] <= 1'b1;
      end
      if (w_count_inc) begin
        r_count <= r_count + 1'b1;
      end
      if (w_rd_fire) begin
        r_resp_valid <= 1'b1;
        r_hit        <= w_rd_hit;
        r_data_out   <= w_rd_data;
      end else if (respReady) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  // Slot payloads need no reset: the valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_tag[w_wr_idx]  <= wrVersion;
      r_data[w_wr_idx] <= wrData;
    end
  end

endmodule

// File: tb/tb_version_store.sv
// tb/tb_version_store.sv - scoreboard bench for version_store: directed scenarios
// followed by random traffic against a tag-keyed reference store.
module tb_version_store;

  localparam int DW = 32;
  localparam int VW = 4;
  localparam int VN = 4;

  typedef struct {
    logic          hit;
    logic [DW-1:0] data;
  } resp_t;

  logic          clk;
  logic          rstN;
  logic          wrValid;
  logic          wrReady;
  logic [VW-1:0] wrVersion;
  logic [DW-1:0] wrData;
  logic          rdValid;
  logic          rdReady;
  logic [VW-1:0] readVersion;
  logic          respValid;
  logic          respReady;
  logic [DW-1:0] dataOut;
  logic          hit;
  logic [2:0]    count;
  logic          drop;

  int            n_vec;
  int            n_err;
  resp_t         exp_q[$];
  logic [DW-1:0] m_store[int];
  logic          m_resp_valid;
  logic          m_drop_exp;

  version_store #(.DATA_WIDTH(DW), .VERSION_WIDTH(VW), .VERSION_NUM(VN)) dut (
    .clk(clk), .rstN(rstN),
    .wrValid(wrValid), .wrReady(wrReady), .wrVersion(wrVersion), .wrData(wrData),
    .rdValid(rdValid), .rdReady(rdReady), .readVersion(readVersion),
    .respValid(respValid), .respReady(respReady), .dataOut(dataOut), .hit(hit),
    .count(count), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_write(input int v, input logic [DW-1:0] d);
    int mn;
    if (m_store.exists(v) || (m_store.size() < VN)) begin
      m_store[v] = d;
      return 1'b0;
    end
    void'(m_store.first(mn));
    if (v > mn) begin
      m_store.delete(mn);
      m_store[v] = d;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic resp_t model_read(input int v);
    resp_t r;
    r.hit  = 1'b0;
    r.data = '0;
    foreach (m_store[key]) begin
      if (key <= v) begin
        r.hit  = 1'b1;
        r.data = m_store[key];
      end
    end
    return r;
  endfunction

  // Monitor: every presented response is compared against the queue head.
  always @(negedge clk) begin
    if (rstN && respValid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL resp_unexpected: got respValid=1 expected no response at %0t", $time);
      end else begin
        chk("resp_hit", hit, exp_q[0].hit);
        chk("resp_data", dataOut, exp_q[0].data);
        if (respReady) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cycle(input logic wv, input int wver, input logic [DW-1:0] wd,
                       input logic rv, input int rver, input logic rr);
    logic rdy;
    wrValid     = wv;
    wrVersion   = wver[VW-1:0];
    wrData      = wd;
    rdValid     = rv;
    readVersion = rver[VW-1:0];
    respReady   = rr;
    @(negedge clk);
    chk("wr_ready", wrReady, 1);
    chk("count", count, m_store.size());
    chk("drop", drop, m_drop_exp);
    rdy = !m_resp_valid || rr;
    chk("rd_ready", rdReady, rdy);
    if (rv && rdy) exp_q.push_back(model_read(rver));
    m_resp_valid = (rv && rdy) ? 1'b1 : (rr ? 1'b0 : m_resp_valid);
    m_drop_exp   = wv ? model_write(rver == rver ? wver : wver, wd) : 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int v, input logic [DW-1:0] d);
    cycle(1'b1, v, d, 1'b0, 0, 1'b1);
  endtask

  task automatic rd(input int v);
    cycle(1'b0, 0, '0, 1'b1, v, 1'b1);
  endtask

  task automatic do_reset();
    wrValid   = 1'b0;
    rdValid   = 1'b0;
    respReady = 1'b1;
    rstN      = 1'b0;
    #1;
    chk("rst_resp_valid", respValid, 0);
    chk("rst_count", count, 0);
    chk("rst_drop", drop, 0);
    chk("rst_hit", hit, 0);
    chk("rst_data", dataOut, 0);
    chk("rst_rd_ready", rdReady, 1);
    chk("rst_wr_ready", wrReady, 0);
    m_store.delete();
    exp_q.delete();
    m_resp_valid = 1'b0;
    m_drop_exp   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    clk = 1'b0;
    rstN = 1'b1;
    wrValid = 1'b0; wrVersion = '0; wrData = '0;
    rdValid = 1'b0; readVersion = '0; respReady = 1'b1;
    m_resp_valid = 1'b0;
    m_drop_exp = 1'b0;
    #2;
    do_reset();

    rd(5);
    chk("r025_valid", respValid, 1);
    chk("r025_hit", hit, 0);
    chk("r025_data", dataOut, 0);

    wr(2, 32'hA);
    wr(6, 32'hB);
    rd(5);
    chk("r026_rd5_hit", hit, 1);
    chk("r026_rd5_data", dataOut, 32'hA);
    rd(6);
    chk("r026_rd6_data", dataOut, 32'hB);
    rd(1);
    chk("r026_rd1_hit", hit, 0);
    chk("r026_count", count, 2);

    do_reset();
    for (int v = 3; v <= 9; v += 2) wr(v, 32'h30 + v);
    wr(10, 32'hC);
    chk("r027_count", count, 4);
    rd(3);
    chk("r027_evicted_hit", hit, 0);
    wr(1, 32'hEE);
    chk("r027_drop_pulse", drop, 1);
    rd(9);
    chk("r027_drop_clear", drop, 0);
    chk("r027_rd9_data", dataOut, 32'h39);

    do_reset();
    wr(5, 32'h1);
    wr(5, 32'h2);
    chk("r028_count", count, 1);
    rd(15);
    chk("r028_data", dataOut, 32'h2);

    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 0, '0, 1'b1, 4, 1'b0);
      chk("r029_rd_ready_low", rdReady, 0);
      chk("r029_data_stable", dataOut, 32'h2);
    end
    cycle(1'b0, 0, '0, 1'b1, 4, 1'b1);
    chk("r029_new_valid", respValid, 1);
    chk("r029_new_hit", hit, 0);

    do_reset();
    cycle(1'b1, 4, 32'hD, 1'b1, 4, 1'b1);
    chk("r030_same_edge_hit", hit, 0);
    rd(4);
    chk("r030_hit", hit, 1);
    chk("r030_data", dataOut, 32'hD);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle(($urandom_range(0, 1) == 1), $urandom_range(0, 15), $urandom,
            ($urandom_range(0, 1) == 1), $urandom_range(0, 15),
            ($urandom_range(0, 9) < 7));
    end

    repeat (3) cycle(1'b0, 0, '0, 1'b0, 0, 1'b1);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/version_store.md
VERSION_STORE -- requirements
Module: version_store

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter VERSION_WIDTH, default 4, version tag width in bits, unsigned.
REQ-003 SHALL have parameter VERSION_NUM, default 4, number of storage slots (>=2).
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge; rstN  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: wrValid  in  1  write request; wrReady  out  1  write accept; wrVersion  in  VERSION_WIDTH  tag; wrData  in  DATA_WIDTH  payload.
REQ-006 SHALL have ports: rdValid  in  1  read request; rdReady  out  1  read accept; readVersion  in  VERSION_WIDTH  requested version.
REQ-007 SHALL have ports: respValid  out  1  response valid; respReady  in  1  response accept; dataOut  out  DATA_WIDTH  result; hit  out  1  match found.
REQ-008 SHALL have ports: count  out  $clog2(VERSION_NUM+1)  occupied slots; drop  out  1  one-cycle pulse, write discarded.

Function
REQ-009 Write handshake SHALL complete on a rising edge with wrValid && wrReady; wrReady SHALL be 1 whenever out of reset.
REQ-010 Accepted write whose wrVersion equals a stored tag SHALL overwrite that slot's data; count unchanged.
REQ-011 Otherwise, if count < VERSION_NUM, the write SHALL fill the lowest-index free slot; count increments by 1.
REQ-012 Otherwise (full), if wrVersion > smallest stored tag, the write SHALL replace the slot holding the smallest tag (lowest index on tie impossible; tags unique).
REQ-013 Full and wrVersion < smallest stored tag: write SHALL be discarded, contents unchanged, drop=1 for the following cycle only.
REQ-014 Tags SHALL compare as plain unsigned values; no wrap-around handling.
REQ-015 Read handshake SHALL complete on rdValid && rdReady; rdReady SHALL equal !respValid || respReady.
REQ-016 On read accept, response SHALL be registered and respValid SHALL be 1 on the next cycle (latency 1).
REQ-017 Selected slot SHALL be the valid slot with greatest tag <= readVersion; hit=1, dataOut=its data.
REQ-018 No valid slot with tag <= readVersion: hit=0, dataOut=0.
REQ-019 respValid, dataOut, hit SHALL hold stable while respValid && !respReady.
REQ-020 Response SHALL clear (respValid=0) after respReady handshake unless a new read is accepted same edge, in which case the new result loads.
REQ-021 Write and read accepted on same edge: read SHALL see contents before that write.
REQ-022 count SHALL never exceed VERSION_NUM; dataOut SHALL never reflect an unoccupied slot.

Reset
REQ-023 rstN low SHALL immediately clear all slot valid bits, count=0, respValid=0, hit=0, dataOut=0, drop=0, rdReady=1, wrReady=0.
REQ-024 Reset mid-handshake SHALL discard any pending response; first post-reset edge with rstN high SHALL accept requests normally.

Verification
REQ-025 Reset, read readVersion=5 -> next cycle respValid=1, hit=0, dataOut=0.
REQ-026 Write (v=2,d=0xA),(v=6,d=0xB); read 5 -> hit=1, dataOut=0xA; read 6 -> 0xB; read 1 -> hit=0; count=2.
REQ-027 Fill v=3,5,7,9 (VERSION_NUM=4), write v=10 d=0xC -> slot of v=3 replaced, count=4; write v=1 -> drop pulse one cycle, read 9 still returns v=9 data.
REQ-028 Write v=5 d=0x1 then v=5 d=0x2 -> count=1, read 15 -> dataOut=0x2.
REQ-029 Hold respReady=0 for 3 cycles with rdValid=1 -> rdReady=0, dataOut stable; raise respReady -> next read loads following cycle.
REQ-030 Same edge: write v=4 d=0xD and read 4 on empty store -> hit=0; subsequent read 4 -> hit=1, dataOut=0xD; assert rstN low with respValid=1 -> respValid=0 immediately.
